// File: rtl/ram_sdp.sv
// ram_sdp -- simple dual-port RAM, one write port and one read port on a
// single clock.
//
// Parameters
//   addr_width : address bit width; depth is 2**addr_width words
//   data_width : word bit width
//
// Ports
//   CLK      : clock, all state updates on the rising edge
//   RESET_N  : asynchronous active-low reset; clears Q_R only, never memory
//   ADDR_W   : write address
//   ENABLE_W : write enable, active-high
//   Q_W      : write data
//   ADDR_R   : read address, sampled every rising edge (no read enable)
//   Q_R      : registered read data, one-cycle latency, read-first on
//              same-address collision
module ram_sdp #(
  parameter int addr_width = 10,
  parameter int data_width = 32
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [addr_width-1:0] ADDR_W,
  input  logic                  ENABLE_W,
  input  logic [data_width-1:0] Q_W,
  input  logic [addr_width-1:0] ADDR_R,
  output logic [data_width-1:0] Q_R
);

  localparam int Depth = 2 ** addr_width;

  // Storage has no reset and no power-up value, so it maps onto block RAM.
  logic [data_width-1:0] mem_q [Depth];

  logic [data_width-1:0] rdata_q;
  logic [data_width-1:0] rdata_d;

  // Writes are suppressed while reset is held; the memory array itself keeps
  // its contents across reset.
  always_ff @(posedge CLK) begin
    if (RESET_N && ENABLE_W) begin
      mem_q[ADDR_W] <= Q_W;
    end
  end

  // The read samples the array before this edge's write lands, which gives
  // read-first behaviour when ADDR_R == ADDR_W.
  always_comb begin
    rdata_d = mem_q[ADDR_R];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign Q_R = rdata_q;

endmodule

// File: tb/tb_ram_sdp.sv
module tb_ram_sdp;

  logic        CLK;
  logic        RESET_N;
  logic [9:0]  ADDR_W;
  logic        ENABLE_W;
  logic [31:0] Q_W;
  logic [9:0]  ADDR_R;
  logic [31:0] Q_R;

  int checks;
  int failures;

  typedef struct {
    logic        en;
    logic [9:0]  aw;
    logic [31:0] d;
    logic [9:0]  ar;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;

  vec_t        vecs [17];
  sb_t         sb [$];
  logic [31:0] model [int];

  ram_sdp #(.addr_width(10), .data_width(32)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .ADDR_W  (ADDR_W),
    .ENABLE_W(ENABLE_W),
    .Q_W     (Q_W),
    .ADDR_R  (ADDR_R),
    .Q_R     (Q_R)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: Q_R=%h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus; an expected read result is queued now and
  // popped once the edge that produces it has passed.
  task automatic step(input logic en, input logic [9:0] aw, input logic [31:0] d,
                      input logic [9:0] ar, input logic chk, input logic [31:0] exp,
                      input string nm);
    sb_t e;
    ENABLE_W = en;
    ADDR_W   = aw;
    Q_W      = d;
    ADDR_R   = ar;
    if (chk) sb.push_back('{exp, nm});
    if (en && RESET_N) model[int'(aw)] = d;
    @(posedge CLK);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, Q_R, e.exp);
    end
  endtask

  initial begin
    logic        ren;
    logic [9:0]  raw;
    logic [9:0]  rar;
    logic [31:0] rd;
    logic        rchk;
    logic [31:0] rexp;

    checks   = 0;
    failures = 0;

    vecs[0]  = '{1'b1, 10'd0,    32'hDEADBEEF, 10'd0,    1'b0, 32'h0};
    vecs[1]  = '{1'b0, 10'd0,    32'h0,        10'd0,    1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 10'd1,    32'h11111111, 10'd0,    1'b1, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 10'd2,    32'h22222222, 10'd1,    1'b1, 32'h11111111};
    vecs[4]  = '{1'b0, 10'd0,    32'h0,        10'd2,    1'b1, 32'h22222222};
    vecs[5]  = '{1'b1, 10'd2,    32'h33333333, 10'd2,    1'b1, 32'h22222222};
    vecs[6]  = '{1'b0, 10'd0,    32'h0,        10'd2,    1'b1, 32'h33333333};
    vecs[7]  = '{1'b0, 10'd1,    32'hFFFFFFFF, 10'd0,    1'b1, 32'hDEADBEEF};
    vecs[8]  = '{1'b0, 10'd1,    32'hFFFFFFFF, 10'd0,    1'b1, 32'hDEADBEEF};
    vecs[9]  = '{1'b0, 10'd1,    32'hFFFFFFFF, 10'd0,    1'b1, 32'hDEADBEEF};
    vecs[10] = '{1'b0, 10'd0,    32'h0,        10'd1,    1'b1, 32'h11111111};
    vecs[11] = '{1'b1, 10'd1023, 32'hA5A5A5A5, 10'd1,    1'b1, 32'h11111111};
    vecs[12] = '{1'b1, 10'd0,    32'h5A5A5A5A, 10'd1023, 1'b1, 32'hA5A5A5A5};
    vecs[13] = '{1'b0, 10'd0,    32'h0,        10'd0,    1'b1, 32'h5A5A5A5A};
    vecs[14] = '{1'b1, 10'd1023, 32'h00000001, 10'd0,    1'b1, 32'h5A5A5A5A};
    vecs[15] = '{1'b1, 10'd1023, 32'h00000002, 10'd1023, 1'b1, 32'h00000001};
    vecs[16] = '{1'b0, 10'd0,    32'h0,        10'd1023, 1'b1, 32'h00000002};

    ENABLE_W = 1'b0;
    ADDR_W   = '0;
    Q_W      = '0;
    ADDR_R   = '0;
    RESET_N  = 1'b1;
    #3 RESET_N = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check("reset_state", Q_R, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;

    for (int i = 0; i <= 10; i++) begin
      step(vecs[i].en, vecs[i].aw, vecs[i].d, vecs[i].ar, vecs[i].chk, vecs[i].exp,
           $sformatf("vec%0d", i));
    end

    // Q_R must not follow a mid-cycle ADDR_R change.
    ADDR_R = 10'd2;
    #2;
    check("hold_mid_cycle", Q_R, 32'h11111111);

    // Asynchronous reset between edges, with a write attempted while held.
    @(negedge CLK);
    #1 RESET_N = 1'b0;
    #1;
    check("async_reset_clear", Q_R, 32'h0);
    ENABLE_W = 1'b1;
    ADDR_W   = 10'd0;
    Q_W      = 32'hCAFEF00D;
    ADDR_R   = 10'd0;
    @(posedge CLK);
    #1;
    check("reset_hold_zero", Q_R, 32'h0);
    ENABLE_W = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    step(1'b0, 10'd0, 32'h0, 10'd0, 1'b1, 32'hDEADBEEF, "post_reset_addr0");
    step(1'b0, 10'd0, 32'h0, 10'd1, 1'b1, 32'h11111111, "post_reset_addr1");

    for (int i = 11; i <= 16; i++) begin
      step(vecs[i].en, vecs[i].aw, vecs[i].d, vecs[i].ar, vecs[i].chk, vecs[i].exp,
           $sformatf("vec%0d", i));
    end

    // Random traffic against a behavioural read-first model.
    for (int i = 0; i < 300; i++) begin
      ren  = 1'($urandom_range(0, 1));
      raw  = ($urandom_range(0, 9) == 0) ? 10'd1023 : 10'($urandom_range(0, 7));
      rar  = ($urandom_range(0, 9) == 0) ? 10'd1023 : 10'($urandom_range(0, 7));
      rd   = $urandom;
      rchk = model.exists(int'(rar));
      rexp = rchk ? model[int'(rar)] : 32'h0;
      step(ren, raw, rd, rar, rchk, rexp, $sformatf("rand%0d", i));
    end

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
